vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
// - Shares the single-port 2^18 x 8 frame RAM between the VGA pixel fetch and CPU pixel writes.
// - The VGA fetch is hard real-time and always wins. CPU writes are buffered in a small FIFO.
// - The FIFO drains on cycles the VGA leaves free: blanking and gaps between fetches.
// - Sits between data_path store decode (io deco), the VGA timing block and the RAM instance.
// PARAMETERS
// - ADDR_W      18  frame RAM address width
// - DATA_W      8   pixel width
// - FIFO_DEPTH  4   CPU write buffer entries (power of 2, >=2)
// - CNT_W       16  stall counter width
// PORTS
// - clk           in   1       system clock
// - reset         in   1       asynchronous, active-high reset
// - cpu_wr_req    in   1       CPU pixel write request (level; hold until ack)
// - cpu_addr      in   ADDR_W  CPU pixel address
// - cpu_data      in   DATA_W  CPU pixel value
// - cpu_wr_ack    out  1       1-cycle pulse: request accepted into FIFO this cycle
// - cpu_full      out  1       FIFO full (registered)
// - vga_rd_req    in   1       VGA fetch strobe for vga_addr
// - vga_addr      in   ADDR_W  VGA pixel address
// - vga_rd_valid  out  1       vga_pixel holds data for a fetch issued 2 cycles earlier
// - vga_pixel     out  DATA_W  fetched pixel (held between valids)
// - ram_addr      out  ADDR_W  RAM address (registered)
// - ram_data      out  DATA_W  RAM write data (registered)
// - ram_we        out  1       RAM write enable (registered)
// - ram_q         in   DATA_W  RAM read data (RAM registers output; 1-cycle latency)
// - stall_cnt     out  CNT_W   saturating count of cycles with cpu_wr_req=1 and ack=0
// BEHAVIOUR
// - Reset: every output is 0 and the FIFO is emptied. The grant state returns to G_IDLE.
//   - Reset asserted mid-write drops queued entries. No partial ram_we survives.
// - Push: cpu_wr_ack = cpu_wr_req & (~full | pop_this_cycle). This is combinational.
//   - A push and a pop in the same cycle while full is legal, and count stays full.
// - Arbitration is decided each cycle and registered onto the ram_* outputs the next cycle.
//   - vga_rd_req=1: grant G_READ. ram_addr<=vga_addr, ram_we<=0. No pop.
//   - Otherwise, FIFO non-empty: grant G_WRITE. Pop the head: ram_addr/ram_data<=head, ram_we<=1.
//   - Otherwise: grant G_IDLE. ram_we<=0, and ram_addr/ram_data hold their previous value.
// - Read latency: vga_rd_req in cycle N -> ram_addr driven in N+1 -> vga_rd_valid=1 in N+2.
//   - In N+2, vga_pixel<=ram_q is registered at the end of N+2 and held thereafter.
//   - vga_rd_valid is a 2-stage shift of vga_rd_req. It is exact even for back-to-back fetches.
// - Write latency: a push in N makes the entry visible in N+1. The earliest ram_we is N+2.
//   - ram_we is 1 for exactly one cycle per entry. FIFO order is preserved.
// - Write-after-write to the same address: both writes reach the RAM in order, so the last value wins.
// - Read-after-write hazard: no forwarding. VGA may read a stale pixel until the drain completes.
//   This is acceptable for display.
// - Continuous vga_rd_req starves drains indefinitely. Then:
//   - cpu_full rises once FIFO_DEPTH entries are queued.
//   - stall_cnt increments while cpu_wr_req & ~cpu_wr_ack, saturating at all-ones.
//   - stall_cnt clears only on reset.
// - cpu_full is registered: it reflects the count after this cycle's push/pop.
// - FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
//   - empty = ptrs equal; full = MSBs differ and LSBs equal.
// STRUCTURE
// - Package vram_pkg: VRAM_ADDR_W=18, VRAM_DATA_W=8, typedef enum {G_IDLE,G_READ,G_WRITE} grant_t.
//   It also holds typedef struct packed {addr; data} vram_wr_t.
// - Sub-module vram_wr_fifo: sync FIFO of vram_wr_t with push/pop/full/empty.
//   Async active-high reset.
// - The top holds the grant logic, ram_* output registers, the read-valid shift and stall_cnt.
// TESTING
// - Reset: hold reset 3 cycles with random inputs -> all outputs 0. Release -> ram_we stays 0 while idle.
// - Single write: idle, then cpu_wr_req with addr=0x00010, data=0xA5 at N.
//   -> ack at N; ram_we=1, ram_addr=0x00010, ram_data=0xA5 at N+2 only.
// - Read latency: vga_rd_req at N..N+3 (addr 0..3), RAM preloaded with addr value.
//   -> vga_rd_valid in N+2..N+5, pixels 0,1,2,3.
// - Priority/full: vga_rd_req held high, 6 CPU writes offered.
//   -> 4 acks, cpu_full=1, stall_cnt counts +1 per refused cycle, ram_we=0 throughout.
//   Drop vga_rd_req -> 4 writes drain in order on consecutive cycles.
// - Full with simultaneous pop: FIFO full, vga idle, cpu_wr_req=1 -> ack same cycle, cpu_full stays 1.
// - Mid-operation reset: 3 entries queued, assert reset -> FIFO empty, no ram_we after release.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types for the frame RAM arbiter.
//   VRAM_ADDR_W / VRAM_DATA_W : frame RAM geometry (2^18 x 8)
//   grant_t                   : per-cycle owner of the RAM port
//   vram_wr_t                 : one buffered CPU pixel write (address + value)
package vram_pkg;

  localparam int VRAM_ADDR_W = 18;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    G_IDLE  = 2'd0,
    G_READ  = 2'd1,
    G_WRITE = 2'd2
  } grant_t;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } vram_wr_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the frame RAM arbiter and its three neighbours.
//   CPU side : cpu_wr_req/cpu_addr/cpu_data in, cpu_wr_ack/cpu_full out
//   VGA side : vga_rd_req/vga_addr in, vga_rd_valid/vga_pixel out
//   RAM side : ram_addr/ram_data/ram_we out, ram_q in
// slave  = the arbiter; master = the clients and the RAM model around it.
interface vram_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);

  logic              cpu_wr_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_wr_ack;
  logic              cpu_full;

  logic              vga_rd_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_rd_valid;
  logic [DATA_W-1:0] vga_pixel;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  cpu_wr_req, cpu_addr, cpu_data, vga_rd_req, vga_addr, ram_q,
    output cpu_wr_ack, cpu_full, vga_rd_valid, vga_pixel, ram_addr, ram_data, ram_we
  );

  modport master (
    output cpu_wr_req, cpu_addr, cpu_data, vga_rd_req, vga_addr, ram_q,
    input  cpu_wr_ack, cpu_full, vga_rd_valid, vga_pixel, ram_addr, ram_data, ram_we
  );

endinterface

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO buffering CPU pixel writes.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push, din  : enqueue din (caller guarantees ~full or a same-cycle pop)
//   pop, head  : dequeue; head is the oldest entry, valid while ~empty
//   full/empty : status from the registered pointers
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  vram_wr_t din,
  input  logic     pop,
  output vram_wr_t head,
  output logic     full,
  output logic     empty
);

  // One extra pointer bit separates full from empty when the indices match.
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  vram_wr_t         mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg[PTR_W-2:0] == gi[PTR_W-2:0])) mem[gi] <= din;
    end
  end

  assign head  = mem[rd_ptr_reg[PTR_W-2:0]];
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]) &&
                 (wr_ptr_reg[PTR_W-2:0] == rd_ptr_reg[PTR_W-2:0]);

endmodule

// File: rtl/vram_arbiter.sv
// Frame RAM arbiter: VGA fetches always win the single RAM port, CPU
// writes are queued and drained into cycles the VGA leaves free.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : CPU write, VGA fetch and RAM port signals (slave side)
//   stall_cnt  : saturating count of cycles a CPU request was refused
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  vram_arbiter_if.slave    bus,
  output logic [CNT_W-1:0] stall_cnt
);

  grant_t            grant_reg;
  grant_t            grant_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  vram_wr_t          head;
  vram_wr_t          din;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic [DATA_W-1:0] ram_data_reg;
  logic [1:0]        rd_valid_pipe;
  logic [DATA_W-1:0] pixel_reg;

  // Grant decision: VGA first, then a pending CPU write, else idle.
  always_comb begin
    grant_next = G_IDLE;
    if (bus.vga_rd_req)  grant_next = G_READ;
    else if (!fifo_empty) grant_next = G_WRITE;
  end

  assign pop = (grant_next == G_WRITE);
  // A full FIFO still accepts when the head leaves this same cycle.
  // Nothing is accepted while reset is held, so the ack reads 0 then.
  assign push = bus.cpu_wr_req & ~reset & (~fifo_full | pop);

  assign din.addr = bus.cpu_addr;
  assign din.data = bus.cpu_data;

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_reg <= G_IDLE;
    end else begin
      grant_reg <= grant_next;
    end
  end

  // RAM address/data registers; an idle grant keeps the last values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr_reg <= '0;
      ram_data_reg <= '0;
    end else begin
      case (grant_next)
        G_READ: begin
          ram_addr_reg <= bus.vga_addr;
        end
        G_WRITE: begin
          ram_addr_reg <= head.addr;
          ram_data_reg <= head.data;
        end
        default: begin
        end
      endcase
    end
  end

  // rd_valid_pipe[1] marks the cycle in which ram_q carries the fetch
  // issued two cycles earlier; the pixel is captured at the end of it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_pipe <= '0;
      pixel_reg     <= '0;
    end else begin
      rd_valid_pipe <= {rd_valid_pipe[0], bus.vga_rd_req};
      if (rd_valid_pipe[1]) pixel_reg <= bus.ram_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (bus.cpu_wr_req && !push && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.cpu_wr_ack   = push;
  assign bus.cpu_full     = fifo_full;
  assign bus.ram_addr     = ram_addr_reg;
  assign bus.ram_data     = ram_data_reg;
  // Decoded straight from the grant flop: high for exactly one cycle per pop.
  assign bus.ram_we       = (grant_reg == G_WRITE);
  assign bus.vga_rd_valid = rd_valid_pipe[1];
  assign bus.vga_pixel    = pixel_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] stall_cnt;
  int          checks;
  int          errors;
  logic [7:0]  mem [0:1023];

  vram_arbiter_if #(.ADDR_W(18), .DATA_W(8)) vif ();

  vram_arbiter #(
    .ADDR_W     (18),
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (vif.slave),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: registered output, 1-cycle read latency.
  always @(posedge clk) begin
    vif.ram_q <= mem[vif.ram_addr[9:0]];
    if (vif.ram_we) mem[vif.ram_addr[9:0]] <= vif.ram_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vreq, input logic [17:0] vaddr,
                       input logic creq, input logic [17:0] caddr, input logic [7:0] cdata);
    vif.vga_rd_req = vreq;
    vif.vga_addr   = vaddr;
    vif.cpu_wr_req = creq;
    vif.cpu_addr   = caddr;
    vif.cpu_data   = cdata;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   32'(vif.cpu_wr_ack),   32'd0);
    chk({tag, "_full"},  32'(vif.cpu_full),     32'd0);
    chk({tag, "_rv"},    32'(vif.vga_rd_valid), 32'd0);
    chk({tag, "_pix"},   32'(vif.vga_pixel),    32'd0);
    chk({tag, "_raddr"}, 32'(vif.ram_addr),     32'd0);
    chk({tag, "_rdata"}, 32'(vif.ram_data),     32'd0);
    chk({tag, "_we"},    32'(vif.ram_we),       32'd0);
    chk({tag, "_stall"}, 32'(stall_cnt),        32'd0);
  endtask

  typedef struct {
    logic        vreq;
    logic [17:0] vaddr;
    logic        creq;
    logic [17:0] caddr;
    logic [7:0]  cdata;
    logic        ack;
    logic        full;
    logic        we;
    logic [17:0] raddr;
    logic [7:0]  rdata;
    logic        rv;
    logic        cpix;
    logic [7:0]  pix;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [17:0] wa [6];
    logic [7:0]  wd [6];
    int          idx;
    int          exp_stall;
    logic        exp_ack;

    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);

    // ---------------- reset with random inputs ----------------
    reset = 1'b1;
    vif.ram_q = '0;
    drive(1'b0, '0, 1'b0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'($urandom), 18'($urandom), 1'($urandom), 18'($urandom), 8'($urandom));
      #1;
      chk_all_zero($sformatf("rst%0d", c));
      $display("reset cycle %0d: all outputs checked", c);
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0, '0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("idle%0d_we", c), 32'(vif.ram_we), 32'd0);
      chk($sformatf("idle%0d_rv", c), 32'(vif.vga_rd_valid), 32'd0);
      $display("post-reset idle cycle %0d: we=%0d", c, vif.ram_we);
    end

    // ---------------- table: single write, read latency, read-back ----------------
    //          vreq vaddr      creq caddr     cdata   ack full we raddr     rdata  rv cpix pix
    tbl[0]  = '{0, 18'h0,    1, 18'h10, 8'hA5,  1, 0, 0, 18'h0,   8'h00, 0, 1, 8'h00};
    tbl[1]  = '{0, 18'h0,    0, 18'h0,  8'h00,  0, 0, 0, 18'h0,   8'h00, 0, 0, 8'h00};
    tbl[2]  = '{0, 18'h0,    0, 18'h0,  8'h00,  0, 0, 1, 18'h10,  8'hA5, 0, 0, 8'h00};
    tbl[3]  = '{0, 18'h0,    0, 18'h0,  8'h00,  0, 0, 0, 18'h10,  8'hA5, 0, 0, 8'h00};
    tbl[4]  = '{1, 18'h80,   0, 18'h0,  8'h00,  0, 0, 0, 18'h10,  8'hA5, 0, 0, 8'h00};
    tbl[5]  = '{1, 18'h81,   0, 18'h0,  8'h00,  0, 0, 0, 18'h80,  8'hA5, 0, 0, 8'h00};
    tbl[6]  = '{1, 18'h82,   0, 18'h0,  8'h00,  0, 0, 0, 18'h81,  8'hA5, 1, 1, 8'h00};
    tbl[7]  = '{1, 18'h83,   0, 18'h0,  8'h00,  0, 0, 0, 18'h82,  8'hA5, 1, 1, 8'h80};
    tbl[8]  = '{0, 18'h0,    0, 18'h0,  8'h00,  0, 0, 0, 18'h83,  8'hA5, 1, 1, 8'h81};
    tbl[9]  = '{0, 18'h0,    0, 18'h0,  8'h00,  0, 0, 0, 18'h83,  8'hA5, 1, 1, 8'h82};
    tbl[10] = '{0, 18'h0,    0, 18'h0,  8'h00,  0, 0, 0, 18'h83,  8'hA5, 0, 1, 8'h83};
    tbl[11] = '{0, 18'h0,    0, 18'h0,  8'h00,  0, 0, 0, 18'h83,  8'hA5, 0, 1, 8'h83};
    // read back the pixel written above: RAM must now hold 0xA5 at 0x10
    tbl[12] = '{1, 18'h10,   0, 18'h0,  8'h00,  0, 0, 0, 18'h83,  8'hA5, 0, 1, 8'h83};
    tbl[13] = '{0, 18'h0,    0, 18'h0,  8'h00,  0, 0, 0, 18'h10,  8'hA5, 0, 1, 8'h83};
    tbl[14] = '{0, 18'h0,    0, 18'h0,  8'h00,  0, 0, 0, 18'h10,  8'hA5, 1, 1, 8'h83};
    tbl[15] = '{0, 18'h0,    0, 18'h0,  8'h00,  0, 0, 0, 18'h10,  8'hA5, 0, 1, 8'hA5};

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tbl[i].vreq, tbl[i].vaddr, tbl[i].creq, tbl[i].caddr, tbl[i].cdata);
      #1;
      chk($sformatf("v%0d_ack", i),   32'(vif.cpu_wr_ack),   32'(tbl[i].ack));
      chk($sformatf("v%0d_full", i),  32'(vif.cpu_full),     32'(tbl[i].full));
      chk($sformatf("v%0d_we", i),    32'(vif.ram_we),       32'(tbl[i].we));
      chk($sformatf("v%0d_raddr", i), 32'(vif.ram_addr),     32'(tbl[i].raddr));
      chk($sformatf("v%0d_rdata", i), 32'(vif.ram_data),     32'(tbl[i].rdata));
      chk($sformatf("v%0d_rv", i),    32'(vif.vga_rd_valid), 32'(tbl[i].rv));
      if (tbl[i].cpix) chk($sformatf("v%0d_pix", i), 32'(vif.vga_pixel), 32'(tbl[i].pix));
      $display("vec %0d: ack=%0d full=%0d we=%0d addr=0x%0h data=0x%0h rv=%0d pix=0x%0h",
               i, vif.cpu_wr_ack, vif.cpu_full, vif.ram_we, vif.ram_addr,
               vif.ram_data, vif.vga_rd_valid, vif.vga_pixel);
    end
    chk("table_stall", 32'(stall_cnt), 32'd0);

    // ---------------- VGA starvation: fill, refuse, then drain ----------------
    for (int i = 0; i < 6; i++) begin
      wa[i] = 18'h200 + 18'(i);
      wd[i] = 8'h30 + 8'(i);
    end
    idx = 0;
    exp_stall = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(1'b1, 18'h3FF, 1'b1, wa[idx], wd[idx]);
      #1;
      exp_ack = (c < 4);
      chk($sformatf("st%0d_ack", c),   32'(vif.cpu_wr_ack), 32'(exp_ack));
      chk($sformatf("st%0d_full", c),  32'(vif.cpu_full),   32'(c >= 4));
      chk($sformatf("st%0d_we", c),    32'(vif.ram_we),     32'd0);
      chk($sformatf("st%0d_stall", c), 32'(stall_cnt),      32'(exp_stall));
      $display("starve cycle %0d: ack=%0d full=%0d stall=%0d", c, vif.cpu_wr_ack, vif.cpu_full, stall_cnt);
      if (exp_ack) idx++;
      else         exp_stall++;
    end

    // VGA drops with the FIFO full: the pop frees room for a same-cycle push.
    @(negedge clk);
    drive(1'b0, '0, 1'b1, wa[4], wd[4]);
    #1;
    chk("fullpop_ack",   32'(vif.cpu_wr_ack), 32'd1);
    chk("fullpop_full",  32'(vif.cpu_full),   32'd1);
    chk("fullpop_we",    32'(vif.ram_we),     32'd0);
    chk("fullpop_stall", 32'(stall_cnt),      32'(exp_stall));
    $display("full+pop: ack=%0d full=%0d", vif.cpu_wr_ack, vif.cpu_full);

    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      drive(1'b0, '0, 1'b0, '0, '0);
      #1;
      chk($sformatf("dr%0d_full", j),  32'(vif.cpu_full), 32'(j == 1));
      chk($sformatf("dr%0d_we", j),    32'(vif.ram_we),   32'd1);
      chk($sformatf("dr%0d_addr", j),  32'(vif.ram_addr), 32'(wa[j-1]));
      chk($sformatf("dr%0d_data", j),  32'(vif.ram_data), 32'(wd[j-1]));
      $display("drain %0d: we=%0d addr=0x%0h data=0x%0h full=%0d",
               j, vif.ram_we, vif.ram_addr, vif.ram_data, vif.cpu_full);
    end
    @(negedge clk);
    #1;
    chk("dr_end_we",    32'(vif.ram_we), 32'd0);
    chk("dr_end_stall", 32'(stall_cnt),  32'd4);
    $display("drain done: we=%0d stall=%0d", vif.ram_we, stall_cnt);

    // ---------------- mid-operation reset with 3 queued entries ----------------
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, 18'h3FE, 1'b1, 18'h300 + 18'(c), 8'h60 + 8'(c));
      #1;
      chk($sformatf("q%0d_ack", c), 32'(vif.cpu_wr_ack), 32'd1);
      $display("queue %0d: ack=%0d", c, vif.cpu_wr_ack);
    end
    @(negedge clk);
    drive(1'b1, 18'h3FE, 1'b0, '0, '0);
    #1;
    chk("q_full", 32'(vif.cpu_full), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    $display("mid reset asserted: outputs checked");
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0, '0);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mr%0d_we", c),   32'(vif.ram_we),   32'd0);
      chk($sformatf("mr%0d_full", c), 32'(vif.cpu_full), 32'd0);
      chk($sformatf("mr%0d_addr", c), 32'(vif.ram_addr), 32'd0);
      $display("after mid reset %0d: we=%0d addr=0x%0h", c, vif.ram_we, vif.ram_addr);
    end
    chk("mr_stall", 32'(stall_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
